hadamard_pair_sched: RTL and testbench

- Sequencer for the add-then-scale datapath in the QFT state-vector emulator: applies a Hadamard on one target qubit across the whole amplitude memory.
- Walks all amplitude pairs (i, i+2^t), reads both amplitudes, computes out0=(a+b)*h and out1=(a-b)*h, and writes both results back in place.
- Contains four add-scale lanes: sum real, sum imag, diff real, diff imag.
- Sits between the gate-issue controller (start/target/done) and the dual-port amplitude RAM.

---
 rtl/hadamard_pair_sched.sv | 117 +++++++++++
 tb/tb_hadamard_pair_sched.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hadamard_pair_sched.sv
// hadamard_pair_sched: walks every amplitude pair of a target qubit and writes back (a+b)*h, (a-b)*h in place.
module hadamard_pair_sched #(
    parameter int num_qubit      = 4,
    parameter int complexnum_bit = 24,
    parameter int fp_bit         = 22
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [$clog2(num_qubit):0]       target,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic                             rd_en,
    output logic [num_qubit-1:0]             rd_addr0,
    output logic [num_qubit-1:0]             rd_addr1,
    input  logic signed [complexnum_bit-1:0] rd_re0,
    input  logic signed [complexnum_bit-1:0] rd_im0,
    input  logic signed [complexnum_bit-1:0] rd_re1,
    input  logic signed [complexnum_bit-1:0] rd_im1,
    output logic                             wr_en,
    output logic [num_qubit-1:0]             wr_addr0,
    output logic [num_qubit-1:0]             wr_addr1,
    output logic signed [complexnum_bit-1:0] wr_re0,
    output logic signed [complexnum_bit-1:0] wr_im0,
    output logic signed [complexnum_bit-1:0] wr_re1,
    output logic signed [complexnum_bit-1:0] wr_im1
);
    localparam int N  = complexnum_bit;
    localparam int TW = $clog2(num_qubit) + 1;
    localparam int PW = num_qubit - 1;
    localparam logic [TW-1:0] NQ = TW'(num_qubit);
    localparam logic signed [N:0] H = (N+1)'($rtoi(0.70710678 * (2.0 ** fp_bit) + 0.5));
    localparam logic signed [N-1:0] MAXV = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, READ, CALC, WRITE, DONE} state_t;

    state_t st, nst;
    logic [PW-1:0] p;
    logic [TW-1:0] t;
    logic [num_qubit-1:0] pe, mask, a0, a1;
    logic ok;

    // floor-truncated fixed-point scale; upper product bits wrap without saturation
    function automatic logic signed [N-1:0] lane(input logic signed [N-1:0] x, input logic signed [N-1:0] y);
        logic signed [N:0] s;
        logic signed [2*N+1:0] pr;
        s  = {x[N-1], x} + {y[N-1], y};
        pr = (2*N+2)'(s) * (2*N+2)'(H);
        return N'(pr >>> fp_bit);
    endfunction

    function automatic logic signed [N-1:0] nsat(input logic signed [N-1:0] b);
        return (b == MINV) ? MAXV : -b;
    endfunction

    assign ok   = target < NQ;
    assign pe   = num_qubit'(p);
    assign mask = (num_qubit'(1) << t) - num_qubit'(1);
    assign a0   = ((pe >> t) << (t + TW'(1))) | (pe & mask);
    assign a1   = a0 | (num_qubit'(1) << t);

    always_ff @(posedge clk) begin
        if (rst) st <= IDLE;
        else     st <= nst;
    end

    always_comb begin
        nst = st;
        case (st)
            IDLE:    nst = (start && ok) ? READ : IDLE;
            READ:    nst = CALC;
            CALC:    nst = WRITE;
            WRITE:   nst = &p ? DONE : READ;
            default: nst = IDLE;
        endcase
    end

    always_comb begin
        busy     = st == READ || st == CALC || st == WRITE;
        done     = st == DONE;
        rd_en    = st == READ;
        wr_en    = st == WRITE;
        rd_addr0 = rd_en ? a0 : '0;
        rd_addr1 = rd_en ? a1 : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p        <= '0;
            t        <= '0;
            err      <= 1'b0;
            wr_addr0 <= '0;
            wr_addr1 <= '0;
            wr_re0   <= '0;
            wr_im0   <= '0;
            wr_re1   <= '0;
            wr_im1   <= '0;
        end else begin
            err <= st == IDLE && start && !ok;
            if (st == IDLE && start && ok) begin
                p <= '0;
                t <= target;
            end
            if (st == WRITE) p <= p + PW'(1);
            if (st == CALC) begin
                wr_addr0 <= a0;
                wr_addr1 <= a1;
                wr_re0   <= lane(rd_re0, rd_re1);
                wr_im0   <= lane(rd_im0, rd_im1);
                wr_re1   <= lane(rd_re0, nsat(rd_re1));
                wr_im1   <= lane(rd_im0, nsat(rd_im1));
            end
        end
    end
endmodule

// File: tb/tb_hadamard_pair_sched.sv
// tb_hadamard_pair_sched: directed and random Hadamard runs against a RAM model and an arithmetic reference.
module tb_hadamard_pair_sched;
    localparam int SZ = 16;
    localparam longint H = 2965821;

    logic clk = 0, rst = 1, start = 0, load = 0;
    logic [2:0] target = 0;
    logic busy, done, err, rd_en, wr_en;
    logic [3:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
    logic signed [23:0] rd_re0, rd_im0, rd_re1, rd_im1;
    logic signed [23:0] wr_re0, wr_im0, wr_re1, wr_im1;
    logic signed [23:0] mem_re[SZ], mem_im[SZ], init_re[SZ], init_im[SZ], exp_re[SZ], exp_im[SZ];
    int q0[$], q1[$];
    int errs = 0, checks = 0;

    always #5 clk = ~clk;

    hadamard_pair_sched dut (
        .clk(clk), .rst(rst), .start(start), .target(target),
        .busy(busy), .done(done), .err(err),
        .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .rd_re0(rd_re0), .rd_im0(rd_im0), .rd_re1(rd_re1), .rd_im1(rd_im1),
        .wr_en(wr_en), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
        .wr_re0(wr_re0), .wr_im0(wr_im0), .wr_re1(wr_re1), .wr_im1(wr_im1)
    );

    // dual-port RAM with one-cycle read latency
    always @(posedge clk) begin
        if (load) begin
            mem_re <= init_re;
            mem_im <= init_im;
        end else if (wr_en) begin
            mem_re[wr_addr0] <= wr_re0;
            mem_im[wr_addr0] <= wr_im0;
            mem_re[wr_addr1] <= wr_re1;
            mem_im[wr_addr1] <= wr_im1;
        end
        if (rd_en) begin
            rd_re0 <= mem_re[rd_addr0];
            rd_im0 <= mem_im[rd_addr0];
            rd_re1 <= mem_re[rd_addr1];
            rd_im1 <= mem_im[rd_addr1];
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rd_en) begin
            q0.push_back(int'(rd_addr0));
            q1.push_back(int'(rd_addr1));
        end
        if (!rst && (rd_en || wr_en)) chk("rd_wr_exclusive", {126'd0, rd_en, wr_en} & {126'd0, rd_en, rd_en}, {126'd0, rd_en, 1'b0});
    end

    function automatic logic signed [23:0] hmul(input longint s);
        longint pr;
        pr = s * H;
        return 24'(pr >>> 22);
    endfunction

    function automatic longint nneg(input longint b);
        return (b == -8388608) ? 8388607 : -b;
    endfunction

    task automatic model(input int t);
        for (int i = 0; i < SZ; i++) begin
            if (((i >> t) & 1) == 0) begin
                int j;
                j = i | (1 << t);
                exp_re[i] = hmul(longint'(init_re[i]) + longint'(init_re[j]));
                exp_im[i] = hmul(longint'(init_im[i]) + longint'(init_im[j]));
                exp_re[j] = hmul(longint'(init_re[i]) + nneg(longint'(init_re[j])));
                exp_im[j] = hmul(longint'(init_im[i]) + nneg(longint'(init_im[j])));
            end
        end
    endtask

    task automatic clear_init();
        for (int i = 0; i < SZ; i++) begin
            init_re[i] = 0;
            init_im[i] = 0;
        end
    endtask

    task automatic rand_init();
        for (int i = 0; i < SZ; i++) begin
            init_re[i] = ($urandom_range(7, 0) == 0) ? -24'sd8388608 : 24'($urandom);
            init_im[i] = ($urandom_range(7, 0) == 0) ? -24'sd8388608 : 24'($urandom);
        end
    endtask

    task automatic load_mem();
        @(negedge clk) load = 1;
        @(negedge clk) load = 0;
    endtask

    task automatic run(input int t);
        int cyc, rise, dcyc, bcnt, k;
        model(t);
        q0.delete();
        q1.delete();
        cyc = 0; rise = 0; dcyc = 0; bcnt = 0;
        @(negedge clk);
        start = 1;
        target = 3'(t);
        while (cyc < 100 && dcyc == 0) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                start = 0;
                target = 3'($urandom);
            end
            if (busy) begin
                bcnt++;
                if (rise == 0) rise = cyc;
            end
            if (done) dcyc = cyc;
        end
        chk("busy_rise", 128'(rise), 128'(1));
        chk("busy_cycles", 128'(bcnt), 128'(24));
        chk("done_cycle", 128'(dcyc), 128'(25));
        start = 1;
        target = 3'(t);
        @(negedge clk);
        start = 0;
        chk("start_in_done_ignored", {126'd0, busy, rd_en}, 128'd0);
        @(negedge clk);
        chk("idle_after_done", {126'd0, busy, done}, 128'd0);
        chk("pair_count", 128'(q0.size()), 128'(8));
        k = 0;
        for (int i = 0; i < SZ; i++) begin
            if (((i >> t) & 1) == 0 && k < q0.size()) begin
                chk($sformatf("pair%0d_t%0d", k, t), {64'(q0[k]), 64'(q1[k])}, {64'(i), 64'(i | (1 << t))});
                k++;
            end
        end
        for (int i = 0; i < SZ; i++)
            chk($sformatf("mem%0d_t%0d", i, t), {80'd0, mem_re[i], mem_im[i]}, {80'd0, exp_re[i], exp_im[i]});
    endtask

    initial begin
        int bad;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {11'd0, busy, done, err, rd_en, wr_en, rd_addr0, rd_addr1, wr_addr0, wr_addr1,
                              wr_re0, wr_im0, wr_re1, wr_im1}, 128'd0);
        rst = 0;
        clear_init(); init_re[0] = 24'sd4194304;
        load_mem(); run(0);
        chk("basis_amp0", {80'd0, mem_re[0], mem_im[0]}, {80'd0, 24'sd2965821, 24'sd0});
        chk("basis_amp1", {80'd0, mem_re[1], mem_im[1]}, {80'd0, 24'sd2965821, 24'sd0});
        clear_init();
        init_re[0] = 24'sd4194304; init_im[0] = 24'sd4194304;
        init_re[1] = 24'sd4194304; init_im[1] = 24'sd4194304;
        load_mem(); run(0);
        chk("equal_amp0", {80'd0, mem_re[0], mem_im[0]}, {80'd0, 24'sd5931642, 24'sd5931642});
        chk("equal_amp1", {80'd0, mem_re[1], mem_im[1]}, 128'd0);
        clear_init(); init_re[1] = 24'sd4194304;
        load_mem(); run(0);
        chk("neg_amp1", {80'd0, mem_re[1], mem_im[1]}, {80'd0, -24'sd2965821, 24'sd0});
        clear_init(); init_re[1] = -24'sd8388608;
        load_mem(); run(0);
        chk("sat_amp0", {80'd0, mem_re[0], mem_im[0]}, {80'd0, -24'sd5931642, 24'sd0});
        chk("sat_amp1", {80'd0, mem_re[1], mem_im[1]}, {80'd0, 24'sd5931641, 24'sd0});
        rand_init(); load_mem(); run(2);
        for (int r = 0; r < 6; r++) begin
            rand_init(); load_mem(); run(int'($urandom_range(3, 0)));
        end
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            start = 1;
            target = 3'($urandom_range(7, 4));
            @(negedge clk);
            start = 0;
            chk("reject_err_pulse", {127'd0, err}, 128'd1);
            bad = 0;
            for (int c = 0; c < 4; c++) begin
                if (busy || rd_en || wr_en || (c > 0 && err)) bad++;
                @(negedge clk);
            end
            chk("reject_quiet", 128'(bad), 128'd0);
        end
        rand_init(); load_mem();
        @(negedge clk);
        start = 1;
        target = 3'd1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) start = 0;
        end
        chk("abort_in_write", {127'd0, wr_en}, 128'd1);
        rst = 1;
        @(negedge clk);
        chk("abort_idle", {124'd0, wr_en, busy, done, rd_en}, 128'd0);
        rst = 0;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done || busy) bad++;
        end
        chk("abort_no_done", 128'(bad), 128'd0);
        rand_init(); load_mem(); run(3);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
